// File: rtl/rtc_bus_responder.sv
// rtl/rtc_bus_responder.sv - register responder for a multiplexed, active-low-strobe address/data bus.
// Bus pins are sampled into s_*; edges are taken against p_*. Write actions are applied one cycle after detection.
module rtc_bus_responder #(
   parameter int DW   = 8,
   parameter int NREG = 16
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          ChipSelect,
   input  logic          Read,
   input  logic          Write,
   input  logic          AoD,
   input  logic [DW-1:0] data_in,
   output logic [DW-1:0] data_out,
   output logic          data_oe,
   output logic [DW-1:0] addr_q,
   output logic          err
);
   localparam int AW = $clog2(NREG);
   localparam logic [DW:0] NREG_L = (DW+1)'(NREG);
   localparam logic [DW:0] CNT_L  = (DW+1)'(NREG - 1);

   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

   state_t        state_q, state_d;
   logic          s_cs_q, s_rd_q, s_wr_q, s_aod_q, p_cs_q, p_wr_q;
   logic [DW-1:0] s_data_q;
   logic [DW-1:0] wbuf_q, wbuf_d, addr_d, data_out_q, data_out_d;
   logic          data_oe_q, data_oe_d, err_q, err_d, abort_q, abort_d;
   logic          ld_addr_q, ld_addr_d, commit_q, commit_d;
   logic [DW-1:0] regs_q [NREG];
   logic [DW-1:0] regs_d [NREG];
   logic          wr_rise, cs_rise, err_event, in_range;
   logic [AW-1:0] addr_idx;

   assign data_out = data_out_q;
   assign data_oe  = data_oe_q;
   assign err      = err_q;
   assign addr_idx = addr_q[AW-1:0];
   assign in_range = ({1'b0, addr_q} < NREG_L);

   always_comb begin
      wr_rise   = !p_wr_q && s_wr_q;
      cs_rise   = !p_cs_q && s_cs_q;
      err_event = !s_cs_q && !s_rd_q && !s_wr_q;

      state_d = s_cs_q ? IDLE : (s_aod_q ? DATA : ADDR);

      wbuf_d = wbuf_q;
      if (state_q != IDLE && !s_wr_q) wbuf_d = s_data_q;
      if (cs_rise && !s_wr_q) wbuf_d = '0;

      // An aborted strobe stays poisoned until Write has returned high.
      abort_d = abort_q;
      if (err_event || (cs_rise && !s_wr_q)) abort_d = 1'b1;
      else if (s_wr_q) abort_d = 1'b0;

      err_d     = err_q | err_event;
      ld_addr_d = wr_rise && !s_cs_q && !abort_q && (state_q == ADDR);
      commit_d  = wr_rise && !s_cs_q && !abort_q && (state_q == DATA);

      addr_d = addr_q;
      if (ld_addr_q) addr_d = wbuf_q;

      // The last location is the write counter, so it never takes bus data.
      regs_d = regs_q;
      if (commit_q && ({1'b0, addr_q} < CNT_L)) begin
         regs_d[addr_idx] = wbuf_q;
         regs_d[NREG-1]   = regs_q[NREG-1] + DW'(1);
      end

      data_oe_d  = !s_cs_q && s_aod_q && !s_rd_q && (state_q == DATA);
      data_out_d = '0;
      if (data_oe_d) data_out_d = in_range ? regs_q[addr_idx] : '1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s_cs_q     <= 1'b1;
         s_rd_q     <= 1'b1;
         s_wr_q     <= 1'b1;
         s_aod_q    <= 1'b0;
         p_cs_q     <= 1'b1;
         p_wr_q     <= 1'b1;
         s_data_q   <= '0;
         state_q    <= IDLE;
         wbuf_q     <= '0;
         addr_q     <= '0;
         data_out_q <= '0;
         data_oe_q  <= 1'b0;
         err_q      <= 1'b0;
         abort_q    <= 1'b0;
         ld_addr_q  <= 1'b0;
         commit_q   <= 1'b0;
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      end else begin
         s_cs_q     <= ChipSelect;
         s_rd_q     <= Read;
         s_wr_q     <= Write;
         s_aod_q    <= AoD;
         p_cs_q     <= s_cs_q;
         p_wr_q     <= s_wr_q;
         s_data_q   <= data_in;
         state_q    <= state_d;
         wbuf_q     <= wbuf_d;
         addr_q     <= addr_d;
         data_out_q <= data_out_d;
         data_oe_q  <= data_oe_d;
         err_q      <= err_d;
         abort_q    <= abort_d;
         ld_addr_q  <= ld_addr_d;
         commit_q   <= commit_d;
         regs_q     <= regs_d;
      end
   end
endmodule

// File: tb/tb_rtc_bus_responder.sv
// tb/tb_rtc_bus_responder.sv - directed bench for rtc_bus_responder.
module tb_rtc_bus_responder;
   logic       clk = 1'b0;
   logic       reset_n, ChipSelect, Read, Write, AoD;
   logic [7:0] data_in, data_out, addr_q;
   logic       data_oe, err;
   int         n_chk = 0;
   int         n_err = 0;

   rtc_bus_responder #(.DW(8), .NREG(16)) dut (
      .clk(clk), .reset_n(reset_n), .ChipSelect(ChipSelect), .Read(Read),
      .Write(Write), .AoD(AoD), .data_in(data_in), .data_out(data_out),
      .data_oe(data_oe), .addr_q(addr_q), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bus_idle();
      ChipSelect = 1'b1; Read = 1'b1; Write = 1'b1; AoD = 1'b0;
   endtask

   task automatic wr_phase(input logic aod, input logic [7:0] d);
      ChipSelect = 1'b0; AoD = aod; data_in = d;
      tick(1);
      Write = 1'b0;
      tick(6);
      Write = 1'b1;
      tick(1);
      ChipSelect = 1'b1;
      tick(3);
   endtask

   task automatic do_read(input logic [7:0] exp, input string tag);
      int first = -1;
      int cnt = 0;
      logic [7:0] seen = 8'h00;
      ChipSelect = 1'b0; AoD = 1'b1;
      tick(1);
      Read = 1'b0;
      for (int i = 1; i <= 9; i++) begin
         tick(1);
         if (data_oe) begin
            if (first < 0) begin
               first = i;
               seen = data_out;
            end
            cnt++;
         end
         if (i == 6) Read = 1'b1;
      end
      chk({tag, " oe_latency"}, first, 2);
      chk({tag, " oe_cycles"}, cnt, 6);
      chk({tag, " rdata"}, seen, exp);
      chk({tag, " oe_off"}, data_oe, 0);
      chk({tag, " dout_off"}, data_out, 0);
      ChipSelect = 1'b1;
      tick(2);
   endtask

   task automatic read_reg(input logic [7:0] a, input logic [7:0] exp, input string tag);
      wr_phase(1'b0, a);
      do_read(exp, tag);
   endtask

   initial begin
      int cnt;
      bus_idle();
      data_in = 8'h00;
      reset_n = 1'b0;
      tick(2);
      chk("rst data_oe", data_oe, 0);
      chk("rst data_out", data_out, 0);
      chk("rst addr_q", addr_q, 0);
      chk("rst err", err, 0);
      reset_n = 1'b1;
      tick(2);

      // address load lands exactly three edges after the pin-level Write rise
      ChipSelect = 1'b0; AoD = 1'b0; data_in = 8'h03;
      tick(1);
      Write = 1'b0;
      tick(6);
      Write = 1'b1;
      tick(2);
      chk("addr lat edge2", addr_q, 8'h00);
      tick(1);
      chk("addr lat edge3", addr_q, 8'h03);
      ChipSelect = 1'b1;
      tick(3);

      wr_phase(1'b1, 8'h5A);
      do_read(8'h5A, "rd reg3");
      read_reg(8'h0F, 8'h01, "cnt after 1");

      // Read strobe during an address phase is ignored
      ChipSelect = 1'b0; AoD = 1'b0;
      tick(1);
      Read = 1'b0;
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         tick(1);
         if (data_oe) cnt++;
      end
      Read = 1'b1;
      ChipSelect = 1'b1;
      tick(2);
      chk("rd in addr oe", cnt, 0);

      wr_phase(1'b0, 8'h20);
      wr_phase(1'b1, 8'h77);
      chk("addr 0x20", addr_q, 8'h20);
      do_read(8'hFF, "rd oob");
      read_reg(8'h0F, 8'h01, "cnt after oob");

      wr_phase(1'b1, 8'h99);
      do_read(8'h01, "cnt after ro wr");

      // ChipSelect rises while Write is still low
      wr_phase(1'b0, 8'h03);
      ChipSelect = 1'b0; AoD = 1'b1; data_in = 8'h11;
      tick(1);
      Write = 1'b0;
      tick(3);
      ChipSelect = 1'b1;
      tick(2);
      Write = 1'b1;
      tick(4);
      // Write and ChipSelect rise together
      ChipSelect = 1'b0; AoD = 1'b1; data_in = 8'h22;
      tick(1);
      Write = 1'b0;
      tick(6);
      Write = 1'b1; ChipSelect = 1'b1;
      tick(4);
      do_read(8'h5A, "rd after aborts");
      read_reg(8'h0F, 8'h01, "cnt after aborts");

      wr_phase(1'b0, 8'h03);
      for (int k = 0; k < 254; k++) wr_phase(1'b1, 8'(k));
      read_reg(8'h0F, 8'hFF, "cnt 255");
      wr_phase(1'b0, 8'h03);
      wr_phase(1'b1, 8'hC3);
      read_reg(8'h0F, 8'h00, "cnt wrap");
      read_reg(8'h03, 8'hC3, "reg3 after wrap");

      // Read and Write low together in the data phase
      ChipSelect = 1'b0; AoD = 1'b1; data_in = 8'h3C;
      tick(1);
      Write = 1'b0;
      tick(2);
      Read = 1'b0;
      tick(2);
      Read = 1'b1;
      tick(2);
      Write = 1'b1;
      tick(1);
      ChipSelect = 1'b1;
      tick(3);
      chk("err set", err, 1);
      do_read(8'hC3, "rd after err");
      read_reg(8'h0F, 8'h00, "cnt after err");
      chk("err sticky", err, 1);

      // reset in the middle of an active read
      ChipSelect = 1'b0; AoD = 1'b1;
      tick(1);
      Read = 1'b0;
      tick(3);
      chk("pre-rst oe", data_oe, 1);
      #1 reset_n = 1'b0;
      #1;
      chk("async rst oe", data_oe, 0);
      chk("async rst dout", data_out, 0);
      chk("async rst addr", addr_q, 0);
      chk("async rst err", err, 0);
      bus_idle();
      tick(1);
      reset_n = 1'b1;
      tick(2);

      // reset while Write is low in a data phase to address 0
      ChipSelect = 1'b0; AoD = 1'b1; data_in = 8'h66;
      tick(1);
      Write = 1'b0;
      tick(3);
      #1 reset_n = 1'b0;
      bus_idle();
      tick(1);
      reset_n = 1'b1;
      tick(3);
      read_reg(8'h00, 8'h00, "reg0 after rst");
      read_reg(8'h03, 8'h00, "reg3 after rst");
      read_reg(8'h0F, 8'h00, "cnt after rst");

      wr_phase(1'b0, 8'h05);
      wr_phase(1'b1, 8'hA5);
      do_read(8'hA5, "rd reg5");
      read_reg(8'h0F, 8'h01, "cnt post rst");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
